key_scan_arbiter: RTL and testbench

- Shares one debounce timer among NKEY active-low push-buttons.
- Round-robin scanning picks a pressed key and locks onto it. The block then debounces the press, reports a single event through a valid/ready handshake, and debounces the release before scanning again.
- Sits between the raw board keys and the display/counter logic in the seg7 designs. It replaces one debounce filter per key.

---
 rtl/key_scan_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_key_scan_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/key_scan_arbiter.sv
// key_scan_arbiter: one shared debounce timer for NKEY active-low keys.
// A round-robin scan locks onto a pressed key. The block then debounces the
// press, reports one event over a valid/ready handshake, and debounces the
// release before it scans again.
// Optional auto-repeat while the key is held: define KEY_SCAN_REPEAT_EN.
module key_scan_arbiter #(
  parameter int unsigned NKEY  = 4,
  parameter int unsigned IDW   = 2,
  parameter int unsigned T_DEB = 1_000_000,
  parameter int unsigned CW    = 32,
  parameter int unsigned T_REP = 25_000_000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NKEY-1:0] key_in,
  output logic            evt_valid,
  input  logic            evt_ready,
  output logic [IDW-1:0]  evt_id,
  output logic [7:0]      evt_cnt,
  output logic            busy
);

  typedef enum logic [1:0] {SCAN, PRESS, REPORT, RELEASE} state_t;

  localparam logic [CW-1:0] DEB_LAST = CW'(T_DEB - 1);

  state_t          state_q, state_d;
  logic [NKEY-1:0] sync_q, ks_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic [IDW-1:0]  lock_q, lock_d;
  logic [IDW-1:0]  evt_id_q, evt_id_d;
  logic [CW-1:0]   count_q, count_d;
  logic            evt_valid_q, evt_valid_d;
  logic [7:0]      evt_cnt_q, evt_cnt_d;

  logic            any_low;
  logic            lock_lvl;
  logic            found;
  logic [IDW-1:0]  pick;
  logic [IDW-1:0]  cand;
  int unsigned     idx;

`ifdef KEY_SCAN_REPEAT_EN
  localparam logic [CW-1:0] REP_LAST = CW'(T_REP - 1);
  logic [CW-1:0] rcount_q, rcount_d;
`else
  // T_REP only matters when auto-repeat is built in.
  if (T_REP == 0) begin : g_no_repeat
  end
`endif

  assign any_low   = ~&ks_q;
  assign lock_lvl  = ks_q[lock_q];
  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_cnt   = evt_cnt_q;
  assign busy      = (state_q != SCAN);

  // Two-flop synchronizer; resets to all-ones so keys read as released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '1;
      ks_q   <= '1;
    end else begin
      sync_q <= key_in;
      ks_q   <= sync_q;
    end
  end

  // Round-robin search: first low key starting at ptr, wrapping modulo NKEY.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    idx   = 0;
    cand  = '0;
    for (int unsigned i = 0; i < NKEY; i++) begin
      idx = 32'(ptr_q) + i;
      if (idx >= NKEY) idx = idx - NKEY;
      cand = IDW'(idx);
      if (!found && !ks_q[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Next-state and datapath updates for the scan/debounce/report FSM.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    lock_d      = lock_q;
    evt_id_d    = evt_id_q;
    count_d     = count_q;
    evt_valid_d = evt_valid_q;
    evt_cnt_d   = evt_cnt_q;
`ifdef KEY_SCAN_REPEAT_EN
    rcount_d    = rcount_q;
`endif
    unique case (state_q)
      SCAN: begin
        if (any_low) begin
          lock_d  = pick;
          count_d = '0;
          state_d = PRESS;
        end
      end
      PRESS: begin
        if (!lock_lvl) begin
          if (count_q == DEB_LAST) begin
            count_d     = '0;
            evt_valid_d = 1'b1;
            evt_id_d    = lock_q;
            state_d     = REPORT;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          count_d = '0;
          state_d = SCAN;
        end
      end
      REPORT: begin
        if (evt_valid_q && evt_ready) begin
          evt_valid_d = 1'b0;
          evt_cnt_d   = evt_cnt_q + 8'd1;
          count_d     = '0;
`ifdef KEY_SCAN_REPEAT_EN
          rcount_d    = '0;
`endif
          state_d     = RELEASE;
        end
      end
      RELEASE: begin
        if (lock_lvl) begin
          if (count_q == DEB_LAST) begin
            count_d = '0;
            ptr_d   = (32'(lock_q) == NKEY - 1) ? '0 : lock_q + 1'b1;
            state_d = SCAN;
          end else begin
            count_d = count_q + 1'b1;
          end
        end else begin
          count_d = '0;
        end
`ifdef KEY_SCAN_REPEAT_EN
        // Held key: count towards a repeat; any high cycle clears it.
        if (lock_lvl) begin
          rcount_d = '0;
        end else if (rcount_q == REP_LAST) begin
          rcount_d    = '0;
          evt_valid_d = 1'b1;
          evt_id_d    = lock_q;
          state_d     = REPORT;
        end else begin
          rcount_d = rcount_q + 1'b1;
        end
`endif
      end
      default: state_d = SCAN;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SCAN;
      ptr_q       <= '0;
      lock_q      <= '0;
      evt_id_q    <= '0;
      count_q     <= '0;
      evt_valid_q <= 1'b0;
      evt_cnt_q   <= '0;
`ifdef KEY_SCAN_REPEAT_EN
      rcount_q    <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      lock_q      <= lock_d;
      evt_id_q    <= evt_id_d;
      count_q     <= count_d;
      evt_valid_q <= evt_valid_d;
      evt_cnt_q   <= evt_cnt_d;
`ifdef KEY_SCAN_REPEAT_EN
      rcount_q    <= rcount_d;
`endif
    end
  end

endmodule

// File: tb/tb_key_scan_arbiter.sv
// Directed bench for key_scan_arbiter with NKEY=4, T_DEB=8, T_REP=20.
// Cycle numbers below count posedges after the key is driven at a negedge:
// 2 sync flops + 1 SCAN cycle + 8 debounce cycles put the event at edge 11.
module tb_key_scan_arbiter;

  localparam int unsigned NKEY  = 4;
  localparam int unsigned IDW   = 2;
  localparam int unsigned T_DEB = 8;
  localparam int unsigned CW    = 32;
  localparam int unsigned T_REP = 20;

  logic            clk = 1'b0;
  logic            rst;
  logic [NKEY-1:0] key_in;
  logic            evt_valid;
  logic            evt_ready;
  logic [IDW-1:0]  evt_id;
  logic [7:0]      evt_cnt;
  logic            busy;

  int n_cmp = 0;
  int n_err = 0;
  int nvalid = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  key_scan_arbiter #(
    .NKEY (NKEY),
    .IDW  (IDW),
    .T_DEB(T_DEB),
    .CW   (CW),
    .T_REP(T_REP)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_in   (key_in),
    .evt_valid(evt_valid),
    .evt_ready(evt_ready),
    .evt_id   (evt_id),
    .evt_cnt  (evt_cnt),
    .busy     (busy)
  );

  typedef struct {
    int key;
    int hold;
    int exp_ev;
    int exp_id;
    int exp_lat;
    int exp_busy_low;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (evt_valid) nvalid++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_cnt = 0;
  endtask

  initial begin
    int nv, lat, id, blow, c, n;
    bit bseen, ok;
    int ids[4];
    int times[4];

    // press key, hold cycles, event?, id, latency, cycle busy falls
    vecs[0] = '{key: 2, hold: 25, exp_ev: 1, exp_id: 2, exp_lat: 11, exp_busy_low: 35};
    vecs[1] = '{key: 1, hold: 5,  exp_ev: 0, exp_id: 0, exp_lat: 0,  exp_busy_low: 8};
    vecs[2] = '{key: 1, hold: 8,  exp_ev: 0, exp_id: 0, exp_lat: 0,  exp_busy_low: 11};
    vecs[3] = '{key: 3, hold: 9,  exp_ev: 1, exp_id: 3, exp_lat: 11, exp_busy_low: 20};
    vecs[4] = '{key: 0, hold: 12, exp_ev: 1, exp_id: 0, exp_lat: 11, exp_busy_low: 22};

    rst = 1'b1;
    key_in = '1;
    evt_ready = 1'b0;
    tick();
    tick();
    check("reset_valid", 32'(evt_valid), 0);
    check("reset_id",    32'(evt_id), 0);
    check("reset_cnt",   32'(evt_cnt), 0);
    check("reset_busy",  32'(busy), 0);
    rst = 1'b0;

    // evt_ready with nothing pending must not count anything.
    evt_ready = 1'b1;
    repeat (6) tick();
    check("idle_ready_cnt",   32'(evt_cnt), 0);
    check("idle_ready_valid", 32'(evt_valid), 0);
    check("idle_busy",        32'(busy), 0);

    // Table-driven single-key presses.
    for (int v = 0; v < 5; v++) begin
      nv = 0; lat = -1; id = -1; blow = -1; bseen = 0;
      evt_ready = 1'b1;
      key_in = '1;
      key_in[vecs[v].key] = 1'b0;
      for (int cy = 1; cy <= 60; cy++) begin
        @(negedge clk);
        if (cy == vecs[v].hold) key_in = '1;
        if (evt_valid) begin
          nv++;
          if (lat < 0) begin
            lat = cy;
            id = int'(evt_id);
          end
        end
        if (busy) bseen = 1;
        else if (bseen && blow < 0) blow = cy;
      end
      check($sformatf("vec%0d_events", v), nv, vecs[v].exp_ev);
      if (vecs[v].exp_ev != 0) begin
        check($sformatf("vec%0d_id", v), id, vecs[v].exp_id);
        check($sformatf("vec%0d_latency", v), lat, vecs[v].exp_lat);
      end
      check($sformatf("vec%0d_busy_low", v), blow, vecs[v].exp_busy_low);
      exp_cnt += vecs[v].exp_ev;
      check($sformatf("vec%0d_cnt", v), 32'(evt_cnt), exp_cnt);
    end

    // Backpressure: event held until accepted, key released meanwhile.
    evt_ready = 1'b0;
    key_in = 4'b1110;
    c = 0;
    while (!evt_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("bp_valid_seen", 32'(evt_valid), 1);
    ok = 1;
    for (int cy = 1; cy <= 20; cy++) begin
      @(negedge clk);
      if (cy == 5) key_in = '1;
      if (!(evt_valid === 1'b1 && evt_id === 2'd0)) ok = 0;
    end
    check("bp_hold_valid_id", 32'(ok), 1);
    check("bp_cnt_before", 32'(evt_cnt), exp_cnt);
    evt_ready = 1'b1;
    @(negedge clk);
    exp_cnt++;
    check("bp_valid_dropped", 32'(evt_valid), 0);
    check("bp_cnt_after", 32'(evt_cnt), exp_cnt);
    repeat (7) @(negedge clk);
    check("bp_busy_edge7", 32'(busy), 1);
    @(negedge clk);
    check("bp_busy_edge8", 32'(busy), 0);
    repeat (5) @(negedge clk);
    check("bp_single_accept", 32'(evt_cnt), exp_cnt);

    // Simultaneous presses of keys 0 and 3 right after reset (ptr=0).
    do_reset();
    evt_ready = 1'b1;
    key_in = 4'b0110;
    n = 0;
    for (int cy = 1; cy <= 100; cy++) begin
      @(negedge clk);
      if (evt_valid) begin
        if (n < 4) ids[n] = int'(evt_id);
        n++;
        if (n == 1) key_in[0] = 1'b1;
        else key_in = '1;
      end
    end
    check("sim_events", n, 2);
    check("sim_first_id", ids[0], 0);
    check("sim_second_id", ids[1], 3);
    check("sim_cnt", 32'(evt_cnt), 2);
    check("sim_idle", 32'(busy), 0);
    exp_cnt = 2;

    // Release bounce on key 1.
    nvalid = 0;
    key_in = 4'b1101;
    repeat (20) tick();
    key_in = '1;
    repeat (4) tick();
    key_in = 4'b1101;
    repeat (2) tick();
    key_in = '1;
    repeat (9) tick();
    check("bounce_busy_edge9", 32'(busy), 1);
    tick();
    check("bounce_busy_edge10", 32'(busy), 0);
    repeat (5) tick();
    check("bounce_one_event", nvalid, 1);
    check("bounce_cnt", 32'(evt_cnt), exp_cnt + 1);

    // Reset while an event is pending.
    evt_ready = 1'b0;
    key_in = 4'b1011;
    c = 0;
    while (!evt_valid && c < 40) begin
      @(negedge clk);
      c++;
    end
    check("rst_pending_valid", 32'(evt_valid), 1);
    check("rst_pending_id", 32'(evt_id), 2);
    key_in = '1;
    rst = 1'b1;
    #1;
    check("rst_async_valid", 32'(evt_valid), 0);
    check("rst_async_id",    32'(evt_id), 0);
    check("rst_async_cnt",   32'(evt_cnt), 0);
    check("rst_async_busy",  32'(busy), 0);
    @(negedge clk);
    rst = 1'b0;
    evt_ready = 1'b1;
    repeat (15) @(negedge clk);
    check("rst_event_lost", 32'(evt_cnt), 0);
    check("rst_idle", 32'(busy), 0);

`ifdef KEY_SCAN_REPEAT_EN
    // Auto-repeat: T_REP cycles in RELEASE plus one REPORT cycle per repeat.
    key_in = 4'b1101;
    n = 0;
    for (int cy = 1; cy <= 90; cy++) begin
      @(negedge clk);
      if (cy == 71) key_in = '1;
      if (evt_valid) begin
        if (n < 4) begin
          times[n] = cy;
          ids[n] = int'(evt_id);
        end
        n++;
      end
    end
    check("rep_events", n, 3);
    check("rep_t0", times[0], 11);
    check("rep_t1", times[1], 32);
    check("rep_t2", times[2], 53);
    check("rep_id", ids[2], 1);
    check("rep_cnt", 32'(evt_cnt), 3);
`else
    times[0] = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1);
  end

endmodule
